// File: rtl/pwm_pkg.sv
// Shared types and defaults for the PWM duty-ramp path.
package pwm_pkg;

  localparam int DUTY_W = 8;
  localparam int STEP_W = 4;
  localparam int RATE_W = 16;

  typedef logic [DUTY_W-1:0] duty_t;

  localparam duty_t DUTY_MAX = '1;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } ramp_state_e;

endpackage

// File: rtl/ramp_prescaler.sv
// Interval counter: ticks once every limit+1 enabled cycles, restartable by clear.
module ramp_prescaler #(
  parameter int RATE_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              en,
  input  logic [RATE_W-1:0] limit,
  output logic              tick
);

  logic [RATE_W-1:0] count;

  assign tick = en && !clear && (count == limit);

  // The count wraps to zero on the tick so the next interval starts cleanly.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (en) begin
      count <= tick ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/pwm_duty_ramp.sv
// Slews a registered duty word toward an accepted target in saturating steps.
module pwm_duty_ramp #(
  parameter int DUTY_W = 8,
  parameter int STEP_W = 4,
  parameter int RATE_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              tgt_valid,
  output logic              tgt_ready,
  input  logic [DUTY_W-1:0] tgt_duty,
  input  logic [STEP_W-1:0] step,
  input  logic [RATE_W-1:0] rate,
  input  logic              abort,
  output logic [DUTY_W-1:0] duty_out,
  output logic              ramping,
  output logic              done
);

  import pwm_pkg::*;

  ramp_state_e       state_q, state_d;
  logic [DUTY_W-1:0] target_q;
  logic [STEP_W-1:0] step_q;
  logic [RATE_W-1:0] rate_q;
  logic              accept;
  logic              step_go;
  logic              tick;
  logic [DUTY_W-1:0] next_duty;
  logic [DUTY_W:0]   step_ext;
  logic [DUTY_W:0]   up_sum;
  logic [DUTY_W:0]   down_diff;

  assign tgt_ready = (state_q == IDLE) && !rst && en;
  assign ramping   = (state_q == RAMP);

  ramp_prescaler #(
    .RATE_W (RATE_W)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .clear (accept),
    .en    (en && (state_q == RAMP)),
    .limit (rate_q),
    .tick  (tick)
  );

  // One extra bit lets the sum and difference be clamped without wrapping.
  assign step_ext  = {{(DUTY_W + 1 - STEP_W){1'b0}}, step_q};
  assign up_sum    = {1'b0, duty_out} + step_ext;
  assign down_diff = {1'b0, duty_out} - step_ext;

  always_comb begin
    next_duty = target_q;
    if (target_q > duty_out) begin
      if (up_sum < {1'b0, target_q}) next_duty = up_sum[DUTY_W-1:0];
    end else if (!down_diff[DUTY_W] && (down_diff[DUTY_W-1:0] > target_q)) begin
      next_duty = down_diff[DUTY_W-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    step_go = 1'b0;
    case (state_q)
      IDLE: begin
        if (tgt_valid && tgt_ready) begin
          accept = 1'b1;
          if (tgt_duty != duty_out) state_d = RAMP;
        end
      end
      RAMP: begin
        if (en) begin
          if (abort) begin
            state_d = IDLE;
          end else if (tick) begin
            step_go = 1'b1;
            if (next_duty == target_q) state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // done is registered so it lines up with the first cycle duty_out shows the target.
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_out <= '0;
      target_q <= '0;
      step_q   <= '0;
      rate_q   <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        target_q <= tgt_duty;
        step_q   <= (step == '0) ? STEP_W'(1) : step;
        rate_q   <= rate;
        if (tgt_duty == duty_out) done <= 1'b1;
      end
      if (step_go) begin
        duty_out <= next_duty;
        if (next_duty == target_q) done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Directed plus randomized bench comparing pwm_duty_ramp against a countdown-based model.
module tb_pwm_duty_ramp;
  import pwm_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic        tgt_valid = 1'b0;
  logic        tgt_ready;
  duty_t       tgt_duty = '0;
  logic [3:0]  step_in = '0;
  logic [15:0] rate_in = '0;
  logic        abort = 1'b0;
  duty_t       duty_out;
  logic        ramping;
  logic        done;

  int checks = 0;
  int errors = 0;

  // Reference model: duty as plain integers, next step scheduled by a countdown.
  int m_duty = 0;
  int m_tgt = 0;
  int m_step = 1;
  int m_rate = 0;
  int m_wait = 0;
  bit m_ramp = 0;
  bit m_done = 0;
  int done_seen = 0;

  pwm_duty_ramp dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .tgt_valid (tgt_valid),
    .tgt_ready (tgt_ready),
    .tgt_duty  (tgt_duty),
    .step      (step_in),
    .rate      (rate_in),
    .abort     (abort),
    .duty_out  (duty_out),
    .ramping   (ramping),
    .done      (done)
  );

  always #5 clk = ~clk;

  function automatic void model_edge();
    m_done = 0;
    if (rst) begin
      m_duty = 0;
      m_tgt  = 0;
      m_ramp = 0;
    end else if (en) begin
      if (!m_ramp) begin
        if (tgt_valid) begin
          m_tgt  = int'(tgt_duty);
          m_step = (step_in == 0) ? 1 : int'(step_in);
          m_rate = int'(rate_in);
          m_wait = m_rate;
          if (m_tgt == m_duty) m_done = 1;
          else m_ramp = 1;
        end
      end else if (abort) begin
        m_ramp = 0;
      end else if (m_wait > 0) begin
        m_wait = m_wait - 1;
      end else begin
        m_wait = m_rate;
        if (m_tgt > m_duty) m_duty = (m_duty + m_step > m_tgt) ? m_tgt : m_duty + m_step;
        else                m_duty = (m_duty - m_step < m_tgt) ? m_tgt : m_duty - m_step;
        if (m_duty == m_tgt) begin
          m_ramp = 0;
          m_done = 1;
        end
      end
    end
  endfunction

  task automatic check_value(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkOutput();
    check_value("duty_out", int'(duty_out), m_duty);
    check_value("done", int'(done), int'(m_done));
    check_value("ramping", int'(ramping), int'(m_ramp));
    check_value("tgt_ready", int'(tgt_ready), int'(!m_ramp && !rst && en));
  endtask

  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      model_edge();
      @(posedge clk);
      #1;
      if (done) done_seen++;
      checkOutput();
    end
  endtask

  task automatic offer(input int tgt, input int stp, input int rt);
    tgt_valid = 1'b1;
    tgt_duty  = duty_t'(tgt);
    step_in   = 4'(stp);
    rate_in   = 16'(rt);
    applyStimulus(1);
    tgt_valid = 1'b0;
  endtask

  task automatic run_to_idle(input string tag);
    int guard = 0;
    while (m_ramp && guard < 2000) begin
      applyStimulus(1);
      guard++;
    end
    if (guard >= 2000) check_value({tag, "_timeout"}, 1, 0);
    applyStimulus(1);
  endtask

  initial begin
    int guard;
    int old_duty;

    // Reset held: ready must stay low while rst is high.
    #1;
    check_value("ready_in_reset", int'(tgt_ready), 0);
    applyStimulus(2);
    rst = 1'b0;
    #1;
    check_value("ready_after_release", int'(tgt_ready), 1);
    applyStimulus(1);
    check_value("reset_duty", int'(duty_out), 0);

    // Up ramp 4..40 every cycle, exactly one done pulse.
    done_seen = 0;
    offer(40, 4, 0);
    run_to_idle("up40");
    check_value("up40_final", int'(duty_out), 40);
    check_value("up40_done_count", done_seen, 1);

    // Down ramp saturating at zero, one step per three cycles.
    offer(0, 15, 2);
    run_to_idle("down0");
    check_value("down0_final", int'(duty_out), 0);

    // Top-end saturation: 250 + 15 must clamp to 255.
    offer(250, 15, 0);
    run_to_idle("to250");
    done_seen = 0;
    offer(int'(DUTY_MAX), 15, 0);
    applyStimulus(1);
    check_value("sat_255", int'(duty_out), 255);
    check_value("sat_ramping", int'(ramping), 0);
    applyStimulus(1);
    check_value("sat_done_count", done_seen, 1);

    // Zero step behaves as one.
    offer(0, 15, 0);
    run_to_idle("back0");
    offer(3, 0, 0);
    applyStimulus(1);
    check_value("step0_first", int'(duty_out), 1);
    run_to_idle("step0");
    check_value("step0_final", int'(duty_out), 3);

    // Freeze mid-ramp with en low.
    offer(100, 5, 3);
    applyStimulus(6);
    old_duty = int'(duty_out);
    en = 1'b0;
    applyStimulus(5);
    check_value("freeze_hold", int'(duty_out), old_duty);
    check_value("freeze_ready", int'(tgt_ready), 0);
    en = 1'b1;
    run_to_idle("freeze");
    check_value("freeze_final", int'(duty_out), 100);

    // Abort at 20, then re-offer the same value for an immediate done.
    offer(0, 10, 0);
    guard = 0;
    while (m_duty != 20 && guard < 50) begin
      applyStimulus(1);
      guard++;
    end
    if (guard >= 50) check_value("abort_reach_timeout", 1, 0);
    abort = 1'b1;
    applyStimulus(1);
    abort = 1'b0;
    check_value("abort_duty", int'(duty_out), 20);
    check_value("abort_idle", int'(ramping), 0);
    applyStimulus(2);
    offer(20, 3, 0);
    check_value("same_tgt_done", int'(done), 1);
    check_value("same_tgt_no_ramp", int'(ramping), 0);

    // A new offer during a ramp is ignored until idle.
    offer(200, 1, 1);
    tgt_valid = 1'b1;
    tgt_duty  = 8'd5;
    applyStimulus(10);
    tgt_valid = 1'b0;
    check_value("ignored_offer_ramp", int'(ramping), 1);

    // Reset mid-ramp.
    rst = 1'b1;
    applyStimulus(1);
    check_value("midrst_duty", int'(duty_out), 0);
    check_value("midrst_ready", int'(tgt_ready), 0);
    rst = 1'b0;
    applyStimulus(2);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      en        = ($urandom_range(0, 9) != 0);
      abort     = ($urandom_range(0, 40) == 0);
      tgt_valid = ($urandom_range(0, 3) == 0);
      tgt_duty  = duty_t'($urandom_range(0, int'(DUTY_MAX)));
      step_in   = 4'($urandom_range(0, 15));
      rate_in   = 16'($urandom_range(0, 3));
      applyStimulus(1);
    end
    en = 1'b1;
    abort = 1'b0;
    tgt_valid = 1'b0;
    run_to_idle("random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
